// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath constants and types
package arith_pkg;

    localparam int WIDTH_8  = 8;
    localparam int BITCNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/eight_bit_serial_subtractor_with_enable.sv
// rtl/eight_bit_serial_subtractor_with_enable.sv - bit-serial a - b - bin0, LSB first
module eight_bit_serial_subtractor_with_enable
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin0,
    output logic [WIDTH-1:0] diff,
    output logic             bout8,
    output logic             busy,
    output logic             done
);

    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WIDTH - 1);

    state_t              state;
    state_t              state_nx;
    logic [WIDTH-1:0]    sha;
    logic [WIDTH-1:0]    shb;
    logic [WIDTH-1:0]    res;
    logic [WIDTH-1:0]    res_nx;
    logic                borrow;
    logic [BITCNT_W-1:0] bitcnt;
    logic                cell_d;
    logic                cell_bout;

    full_subtractor u_fs (
        .a    (sha[0]),
        .b    (shb[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Difference bits enter at the MSB so the result is aligned after WIDTH shifts.
    assign res_nx = {cell_d, res[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (enable && bitcnt == LAST_BIT) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sha    <= '0;
            shb    <= '0;
            res    <= '0;
            borrow <= 1'b0;
            bitcnt <= '0;
            diff   <= '0;
            bout8  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        sha    <= a;
                        shb    <= b;
                        res    <= '0;
                        borrow <= bin0;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        sha    <= sha >> 1;
                        shb    <= shb >> 1;
                        res    <= res_nx;
                        borrow <= cell_bout;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            diff  <= res_nx;
                            bout8 <= cell_bout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_eight_bit_serial_subtractor_with_enable.sv
// tb/tb_eight_bit_serial_subtractor_with_enable.sv - directed bench for the serial subtractor
module tb_eight_bit_serial_subtractor_with_enable;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin0 = 1'b0;
    logic [7:0] diff;
    logic       bout8;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    eight_bit_serial_subtractor_with_enable dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .enable (enable),
        .a      (a),
        .b      (b),
        .bin0   (bin0),
        .diff   (diff),
        .bout8  (bout8),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start, runs to done; returns sampled just after the done-setting edge.
    task automatic do_op(input [7:0] a_v, input [7:0] b_v, input logic bin_v,
                         input logic toggle, input logic poke_start,
                         input [7:0] exp_d, input logic exp_b, input string tag);
        int cycles;
        int stalls;
        logic busy_ok;
        a = a_v; b = b_v; bin0 = bin_v; start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0; stalls = 0; busy_ok = 1'b1;
        while (!done && cycles < 40) begin
            if (!busy) busy_ok = 1'b0;
            enable = toggle ? ((cycles % 2) == 0) : 1'b1;
            if (!enable) stalls++;
            if (poke_start && (cycles == 2 || cycles == 3)) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; bin0 = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        enable = 1'b1;
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_latency"}, cycles, 8 + stalls);
        check({tag, "_busy_thru"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_d});
        check({tag, "_bout8"}, {31'd0, bout8}, {31'd0, exp_b});
    endtask

    task automatic to_idle(input string tag);
        tick();
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_diff", {24'd0, diff}, 32'h00);
        check("rst_bout8", {31'd0, bout8}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        do_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, "op00m01");
        to_idle("op00m01");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, "opFFm01");
        to_idle("opFFm01");
        do_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0, "opFFm00b");
        to_idle("opFFm00b");
        do_op(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h1E, 1'b0, "stall");
        to_idle("stall");

        // Start pokes during SHIFT and DONE must be dropped.
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'hDE, 1'b1, "ignore");
        start = 1'b1; a = 8'hFF; b = 8'hFF; bin0 = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_not_busy", {31'd0, busy}, 32'd0);
        check("ignore_no_done", {31'd0, done}, 32'd0);
        tick();
        check("ignore_still_idle", {31'd0, busy}, 32'd0);
        check("ignore_diff_kept", {24'd0, diff}, 32'hDE);
        do_op(8'h40, 8'h01, 1'b0, 1'b0, 1'b0, 8'h3F, 1'b0, "reaccept");
        to_idle("reaccept");

        // Reset on the fourth shift edge.
        a = 8'h55; b = 8'h11; bin0 = 1'b0; start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_diff", {24'd0, diff}, 32'h00);
        check("midrst_bout8", {31'd0, bout8}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        tick();
        check("midrst_no_done_later", {31'd0, done}, 32'd0);
        check("midrst_stays_idle", {31'd0, busy}, 32'd0);
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b1, "op10m20");
        to_idle("op10m20");

        // Adder round trip: C3 + 7E = 1_41, so 41 - 7E recovers C3 with borrow.
        do_op(8'h41, 8'h7E, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, "roundtrip");
        to_idle("roundtrip");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
